// File: rtl/ibex_wb_stage_rf.sv
// Writeback stage feeding the flip-flop register file write port.
// Holds one retiring instruction, merges ALU or late load data into a single write strobe.
module ibex_wb_stage_rf #(
    parameter int unsigned DataWidth         = 32,
    parameter bit          RV32E             = 1'b0,
    parameter bit          DummyInstructions = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 en_wb_i,
    input  logic [4:0]           wb_rd_i,
    input  logic [DataWidth-1:0] wb_wdata_i,
    input  logic                 wb_we_i,
    input  logic                 wb_load_i,
    input  logic                 wb_dummy_i,
    output logic                 ready_wb_o,

    input  logic                 lsu_resp_valid_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    input  logic                 lsu_err_i,

    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    output logic                 rf_we_o,
    output logic                 dummy_instr_wb_o,

    output logic                 fwd_valid_o,
    output logic [4:0]           fwd_rd_o,
    output logic [DataWidth-1:0] fwd_data_o,

    output logic                 instr_done_wb_o,
    output logic                 err_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ALU       = 2'd1,
        WAIT_LOAD = 2'd2
    } wb_state_e;

    wb_state_e            state_q, state_d;

    logic [4:0]           rd_p1;
    logic [DataWidth-1:0] wdata_p1;
    logic                 we_p1;
    logic                 load_p1;
    logic                 dummy_p1;

    logic                 in_wait;
    logic                 retiring;
    logic                 accept;
    logic                 spurious_resp;
    logic                 rv32e_bad;
    logic                 load_err;
    logic                 wr;
    logic                 dummy_ok;

    // ---- Stage boundary: EX -> WB capture register ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rd_p1    <= '0;
            wdata_p1 <= '0;
            we_p1    <= 1'b0;
            load_p1  <= 1'b0;
            dummy_p1 <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_p1    <= wb_rd_i;
                wdata_p1 <= wb_wdata_i;
                we_p1    <= wb_we_i;
                load_p1  <= wb_load_i;
                dummy_p1 <= wb_dummy_i & DummyInstructions;
            end
        end
    end

    assign in_wait       = (state_q == WAIT_LOAD);
    assign ready_wb_o    = !in_wait || lsu_resp_valid_i;
    assign retiring      = (state_q == ALU) || (in_wait && lsu_resp_valid_i);
    assign accept        = en_wb_i && ready_wb_o;
    // A response outside WAIT_LOAD (including one orphaned by reset) is only flagged.
    assign spurious_resp = lsu_resp_valid_i && !in_wait;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      state_d = IDLE;
            ALU:       state_d = IDLE;
            WAIT_LOAD: state_d = lsu_resp_valid_i ? IDLE : WAIT_LOAD;
            default:   state_d = IDLE;
        endcase
        if (accept) begin
            state_d = wb_load_i ? WAIT_LOAD : ALU;
        end
    end

    // ---- Stage boundary: WB -> register file write port ----
    assign rv32e_bad = RV32E && retiring && we_p1 && rd_p1[4];
    assign load_err  = load_p1 && lsu_err_i;
    assign wr        = retiring && we_p1 && !load_err && !rv32e_bad;
    assign dummy_ok  = DummyInstructions && dummy_p1;

    assign rf_we_o          = wr && ((rd_p1 != 5'd0) || dummy_ok);
    assign rf_waddr_o       = rd_p1;
    assign rf_wdata_o       = load_p1 ? lsu_rdata_i : wdata_p1;
    assign dummy_instr_wb_o = rf_we_o && dummy_ok;

    // Dummy writes to x0 must never become visible to ID.
    assign fwd_valid_o = rf_we_o && (rd_p1 != 5'd0);
    assign fwd_rd_o    = rd_p1;
    assign fwd_data_o  = rf_wdata_o;

    assign instr_done_wb_o = retiring;
    assign err_o           = spurious_resp || rv32e_bad;

endmodule
